// File: rtl/load_balancer_pkg.sv
// Shared types and width helpers for the parametrised least-loaded task dispatcher.
package load_balancer_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      DISPATCH = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int w = 0; w < 31; w++) begin
         if ((1 << w) < value) result = w + 1;
      end
      return result;
   endfunction

   // Index ports stay at least one bit wide even for a single-entry range.
   function automatic int idx_width(input int count);
      return (clog2(count) < 1) ? 1 : clog2(count);
   endfunction

endpackage

// File: rtl/load_balancer_param_least_loaded_select.sv
// Combinational argmin over packed server load counters; servers at full load are
// ineligible and ties resolve to the lowest index.
module least_loaded_select
   import load_balancer_pkg::*;
#(
   parameter int NUM_SERVERS = 3,
   parameter int CNT_WIDTH   = 4
) (
   input  logic [NUM_SERVERS*CNT_WIDTH-1:0]    counts,
   output logic [idx_width(NUM_SERVERS)-1:0]   sel,
   output logic                                any_eligible
);

   localparam int                   SEL_WIDTH = idx_width(NUM_SERVERS);
   localparam logic [CNT_WIDTH-1:0] MAX_LOAD  = '1;

   logic [NUM_SERVERS-1:0] eligible;
   logic [CNT_WIDTH-1:0]   best;
   logic [CNT_WIDTH-1:0]   cur;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      sel          = '0;
      any_eligible = 1'b0;
      best         = MAX_LOAD;
      cur          = '0;
      eligible     = '0;
      for (int i = 0; i < NUM_SERVERS; i++) begin
         cur         = counts[i*CNT_WIDTH +: CNT_WIDTH];
         eligible[i] = (cur != MAX_LOAD);
         // Strict less-than keeps the earlier (lower) index on a tie.
         if (eligible[i] && (!any_eligible || cur < best)) begin
            best         = cur;
            sel          = SEL_WIDTH'(i);
            any_eligible = 1'b1;
         end
      end
   end

endmodule

// File: rtl/load_balancer_param.sv
// Least-loaded dispatcher: accepts a task batch, hands tasks out highest-bit first to the
// least-loaded non-saturated server, and tracks per-server load with completion pulses.
module load_balancer_param
   import load_balancer_pkg::*;
#(
   parameter int TASK_WIDTH  = 8,
   parameter int NUM_SERVERS = 3,
   parameter int CNT_WIDTH   = 4,
   parameter int THRESHOLD   = 3
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                task_valid,
   input  logic [TASK_WIDTH-1:0]               tasks,
   output logic                                task_ready,
   input  logic [NUM_SERVERS-1:0]              done,
   output logic                                assign_valid,
   output logic [idx_width(TASK_WIDTH)-1:0]    assign_task,
   output logic [idx_width(NUM_SERVERS)-1:0]   assign_server,
   output logic [NUM_SERVERS*CNT_WIDTH-1:0]    server_count,
   output logic                                trigger,
   output logic                                overload,
   output logic                                stall
);

   localparam int                   TIDX_W = idx_width(TASK_WIDTH);
   localparam int                   SIDX_W = idx_width(NUM_SERVERS);
   localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(THRESHOLD);

   state_t                          state, state_next;
   logic [TASK_WIDTH-1:0]           pending, pending_next;
   logic [NUM_SERVERS*CNT_WIDTH-1:0] count_next;
   logic [TIDX_W-1:0]               top_task;
   logic [SIDX_W-1:0]               sel_server;
   logic                            any_eligible;
   logic                            dispatch;
   logic                            trigger_next, overload_next;
   logic [CNT_WIDTH-1:0]            cnt;
   logic                            inc, dec;

   least_loaded_select #(
      .NUM_SERVERS (NUM_SERVERS),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_select (
      .counts       (server_count),
      .sel          (sel_server),
      .any_eligible (any_eligible)
   );

   // Later iterations override earlier ones, so the highest set bit wins.
   always_comb begin
      top_task = '0;
      for (int i = 0; i < TASK_WIDTH; i++) begin
         if (pending[i]) top_task = TIDX_W'(i);
      end
   end

   assign task_ready = (state == IDLE);
   assign dispatch   = (state == DISPATCH) && any_eligible;

   always_comb begin
      state_next   = state;
      pending_next = pending;
      case (state)
         IDLE: begin
            if (task_valid && tasks != '0) begin
               pending_next = tasks;
               state_next   = DISPATCH;
            end
         end
         DISPATCH: begin
            if (dispatch) begin
               pending_next[top_task] = 1'b0;
               if (pending_next == '0) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Selection already used the pre-edge counts; a completion and a dispatch on the
   // same server cancel out, and a completion on an empty server is dropped.
   always_comb begin
      count_next    = server_count;
      trigger_next  = 1'b0;
      overload_next = 1'b1;
      cnt           = '0;
      inc           = 1'b0;
      dec           = 1'b0;
      for (int i = 0; i < NUM_SERVERS; i++) begin
         cnt = server_count[i*CNT_WIDTH +: CNT_WIDTH];
         inc = dispatch && (sel_server == SIDX_W'(i));
         dec = done[i] && (cnt != '0);
         if (inc && !dec)      cnt = cnt + 1'b1;
         else if (dec && !inc) cnt = cnt - 1'b1;
         count_next[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
         if (cnt >= THRESH) trigger_next  = 1'b1;
         else               overload_next = 1'b0;
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= '0;
         server_count  <= '0;
         assign_valid  <= 1'b0;
         assign_task   <= '0;
         assign_server <= '0;
         trigger       <= 1'b0;
         overload      <= 1'b0;
         stall         <= 1'b0;
      end else begin
         state        <= state_next;
         pending      <= pending_next;
         server_count <= count_next;
         trigger      <= trigger_next;
         overload     <= overload_next;
         stall        <= (state == DISPATCH) && !any_eligible;
         assign_valid <= dispatch;
         if (dispatch) begin
            assign_task   <= top_task;
            assign_server <= sel_server;
         end
      end
   end

endmodule

// File: tb/tb_load_balancer_param.sv
// Self-checking bench: table-driven spec scenarios, a two-server saturation sequence and
// randomized traffic compared cycle by cycle against a queue-based reference model.
module tb_load_balancer_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Default configuration: 8 tasks, 3 servers, 4-bit counters, threshold 3.
   logic        a_reset, a_valid;
   logic [7:0]  a_tasks;
   logic [2:0]  a_done;
   logic        a_ready, a_av, a_trig, a_ovl, a_stall;
   logic [2:0]  a_at;
   logic [1:0]  a_as;
   logic [11:0] a_cnt;

   load_balancer_param dut_a (
      .clk (clk), .reset (a_reset), .task_valid (a_valid), .tasks (a_tasks),
      .task_ready (a_ready), .done (a_done), .assign_valid (a_av),
      .assign_task (a_at), .assign_server (a_as), .server_count (a_cnt),
      .trigger (a_trig), .overload (a_ovl), .stall (a_stall)
   );

   // Small configuration: 2 servers with 2-bit counters saturate at 3.
   logic        b_reset, b_valid;
   logic [7:0]  b_tasks;
   logic [1:0]  b_done;
   logic        b_ready, b_av, b_trig, b_ovl, b_stall;
   logic [2:0]  b_at;
   logic [0:0]  b_as;
   logic [3:0]  b_cnt;

   load_balancer_param #(
      .TASK_WIDTH (8), .NUM_SERVERS (2), .CNT_WIDTH (2), .THRESHOLD (3)
   ) dut_b (
      .clk (clk), .reset (b_reset), .task_valid (b_valid), .tasks (b_tasks),
      .task_ready (b_ready), .done (b_done), .assign_valid (b_av),
      .assign_task (b_at), .assign_server (b_as), .server_count (b_cnt),
      .trigger (b_trig), .overload (b_ovl), .stall (b_stall)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   // Reference model of the default configuration: a queue of task indices in dispatch order.
   bit m_idle = 1'b1;
   int m_q[$];
   int m_cnt[3] = '{0, 0, 0};
   bit m_av, m_trig, m_ovl, m_stall;
   int m_at, m_as;

   int log_task[$];
   int log_srv[$];
   int ready_low;

   function automatic logic [11:0] pack_a();
      return {4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
   endfunction

   task automatic model_edge(input bit rst, input bit valid, input logic [7:0] tsk,
                             input logic [2:0] dn);
      int best;
      int inc[3];
      inc     = '{0, 0, 0};
      m_av    = 1'b0;
      m_stall = 1'b0;
      if (rst) begin
         m_idle = 1'b1;
         m_q.delete();
         m_cnt  = '{0, 0, 0};
         m_at   = 0;
         m_as   = 0;
         m_trig = 1'b0;
         m_ovl  = 1'b0;
         return;
      end
      if (m_idle) begin
         if (valid && tsk != 8'd0) begin
            for (int b = 7; b >= 0; b--) if (tsk[b]) m_q.push_back(b);
            m_idle = 1'b0;
         end
      end else begin
         best = -1;
         for (int s = 0; s < 3; s++)
            if (m_cnt[s] < 15 && (best < 0 || m_cnt[s] < m_cnt[best])) best = s;
         if (best < 0) m_stall = 1'b1;
         else begin
            m_av      = 1'b1;
            m_at      = m_q.pop_front();
            m_as      = best;
            inc[best] = 1;
            if (m_q.size() == 0) m_idle = 1'b1;
         end
      end
      m_trig = 1'b0;
      m_ovl  = 1'b1;
      for (int s = 0; s < 3; s++) begin
         m_cnt[s] = m_cnt[s] + inc[s] - ((dn[s] && m_cnt[s] > 0) ? 1 : 0);
         if (m_cnt[s] >= 3) m_trig = 1'b1;
         else               m_ovl  = 1'b0;
      end
   endtask

   task automatic tick_a(input bit rst, input bit valid, input logic [7:0] tsk,
                         input logic [2:0] dn);
      a_reset = rst;
      a_valid = valid;
      a_tasks = tsk;
      a_done  = dn;
      model_edge(rst, valid, tsk, dn);
      @(posedge clk);
      #1;
      check("a_ready", a_ready, m_idle);
      check("a_count", a_cnt, pack_a());
      check("a_assign_valid", a_av, m_av);
      if (m_av) begin
         check("a_assign_task", a_at, m_at);
         check("a_assign_server", a_as, m_as);
      end
      check("a_trigger", a_trig, m_trig);
      check("a_overload", a_ovl, m_ovl);
      check("a_stall", a_stall, m_stall);
      if (a_av) begin
         log_task.push_back(int'(a_at));
         log_srv.push_back(int'(a_as));
      end
      if (!a_ready) ready_low++;
   endtask

   task automatic tick_b(input bit rst, input bit valid, input logic [7:0] tsk,
                         input logic [1:0] dn);
      b_reset = rst;
      b_valid = valid;
      b_tasks = tsk;
      b_done  = dn;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int tsk;
      int srv;
   } assign_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      assign_t exp_first[4];
      int      exp_ff_srv[8];
      int      trig_rise_at;
      int      av_after_reset;
      int      n_b;
      bit      stall_seen;
      logic [7:0] r_tsk;
      logic [2:0] r_dn;

      exp_first  = '{'{7, 0}, '{5, 1}, '{2, 2}, '{1, 0}};
      exp_ff_srv = '{1, 2, 0, 1, 2, 0, 1, 2};

      b_reset = 1'b1; b_valid = 1'b0; b_tasks = '0; b_done = '0;

      // Reset state.
      tick_a(1, 0, 8'h00, 3'b000);
      tick_a(1, 0, 8'h00, 3'b000);
      check("reset_ready", a_ready, 1);
      check("reset_count", a_cnt, 12'h000);
      check("reset_assign_valid", a_av, 0);
      check("reset_flags", {a_trig, a_ovl, a_stall}, 3'b000);

      // First batch: tasks 7,5,2,1 spread round the empty pool.
      log_task.delete(); log_srv.delete(); ready_low = 0;
      tick_a(0, 1, 8'b1010_0110, 3'b000);
      repeat (6) tick_a(0, 0, 8'h00, 3'b000);
      check("first_batch_len", log_task.size(), 4);
      for (int i = 0; i < 4 && i < log_task.size(); i++) begin
         check("first_task", log_task[i], exp_first[i].tsk);
         check("first_server", log_srv[i], exp_first[i].srv);
      end
      check("first_counts", a_cnt, {4'd1, 4'd1, 4'd2});
      check("first_trigger", a_trig, 0);
      check("first_ready_low_cycles", ready_low, 4);

      // Full batch on top of {2,1,1}.
      log_task.delete(); log_srv.delete(); trig_rise_at = -1;
      tick_a(0, 1, 8'hFF, 3'b000);
      for (int c = 0; c < 12; c++) begin
         tick_a(0, 0, 8'h00, 3'b000);
         if (a_trig && trig_rise_at < 0) trig_rise_at = log_srv.size();
      end
      check("ff_batch_len", log_srv.size(), 8);
      for (int i = 0; i < 8 && i < log_srv.size(); i++) begin
         check("ff_server", log_srv[i], exp_ff_srv[i]);
         check("ff_task", log_task[i], 7 - i);
      end
      check("ff_trigger_rise_dispatch", trig_rise_at, 3);
      check("ff_counts", a_cnt, 12'h444);
      check("ff_overload", a_ovl, 1);

      // Completion in the same cycle as a dispatch to that server.
      tick_a(0, 1, 8'h01, 3'b000);
      tick_a(0, 0, 8'h00, 3'b001);
      check("same_cycle_valid", a_av, 1);
      check("same_cycle_server", a_as, 0);
      check("same_cycle_count0", a_cnt[3:0], 4'd4);

      // Completion on an empty server.
      tick_a(1, 0, 8'h00, 3'b000);
      tick_a(0, 0, 8'h00, 3'b010);
      check("empty_done_count1", a_cnt[7:4], 4'd0);

      // Reset in the middle of a batch.
      tick_a(0, 1, 8'hFF, 3'b000);
      repeat (3) tick_a(0, 0, 8'h00, 3'b000);
      tick_a(1, 0, 8'h00, 3'b000);
      check("midreset_ready", a_ready, 1);
      check("midreset_outputs", {a_av, a_at, a_as, a_cnt, a_trig, a_ovl, a_stall}, 0);
      av_after_reset = 0;
      repeat (10) begin
         tick_a(0, 0, 8'h00, 3'b000);
         if (a_av) av_after_reset++;
      end
      check("midreset_no_assign", av_after_reset, 0);

      // Empty batch is consumed in IDLE.
      tick_a(0, 1, 8'h00, 3'b000);
      check("zero_batch_ready", a_ready, 1);
      check("zero_batch_no_assign", a_av, 0);
      tick_a(0, 0, 8'h00, 3'b000);
      check("zero_batch_still_idle", a_ready, 1);

      // Random traffic: sparse completions first to reach saturation, then heavier drain.
      for (int c = 0; c < 600; c++) begin
         r_tsk = 8'($urandom);
         if ($urandom_range(0, 7) == 0) r_tsk = 8'h00;
         if (c < 250) r_dn = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
         else         r_dn = 3'($urandom) & 3'($urandom);
         tick_a($urandom_range(0, 199) == 0, 1'($urandom), r_tsk, r_dn);
      end

      // Two-server configuration: saturation stall and recovery through completions.
      tick_a(1, 0, 8'h00, 3'b000);
      tick_b(1, 0, 8'h00, 2'b00);
      tick_b(0, 1, 8'hFF, 2'b00);
      n_b = 0; stall_seen = 1'b0;
      for (int c = 0; c < 20 && !stall_seen; c++) begin
         tick_b(0, 0, 8'h00, 2'b00);
         if (b_av) begin
            check("b_server_alternates", b_as, n_b % 2);
            n_b++;
         end
         if (b_stall) stall_seen = 1'b1;
      end
      check("b_stall_seen", stall_seen, 1);
      check("b_dispatches_before_stall", n_b, 6);
      check("b_pending_not_idle", b_ready, 0);
      check("b_counts_full", b_cnt, 4'b1111);
      check("b_overload", b_ovl, 1);

      tick_b(0, 0, 8'h00, 2'b01);
      check("b_done0_stall", b_stall, 1);
      check("b_done0_no_assign", b_av, 0);
      check("b_done0_counts", b_cnt, 4'b1110);
      tick_b(0, 0, 8'h00, 2'b00);
      check("b_redispatch_valid", b_av, 1);
      check("b_redispatch_server", b_as, 0);
      check("b_redispatch_counts", b_cnt, 4'b1111);
      check("b_one_left", b_ready, 0);
      tick_b(0, 0, 8'h00, 2'b00);
      check("b_stall_again", b_stall, 1);
      tick_b(0, 0, 8'h00, 2'b10);
      check("b_done1_counts", b_cnt, 4'b1011);
      tick_b(0, 0, 8'h00, 2'b00);
      check("b_last_valid", b_av, 1);
      check("b_last_server", b_as, 1);
      check("b_last_ready", b_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
